// File: rtl/play_validator.sv
// Tic-tac-toe move validator: owns the 3x3 board, checks and commits one play at a time,
// scans the eight winning lines one per cycle and reports a one-cycle Ready with V/Win/Tie.
module play_validator #(
    parameter logic [1:0] P0_CODE = 2'b01,
    parameter logic [1:0] P1_CODE = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        ValidatePlay,
    input  logic        Player,
    input  logic [3:0]  position,
    output logic        Ready,
    output logic        V,
    output logic        Win,
    output logic        Tie,
    output logic        busy,
    output logic [17:0] board
);

    typedef enum logic [1:0] {IDLE, CHECK, SCAN, REPORT} state_t;

    state_t          state_q, state_d;
    logic [8:0][1:0] board_q, board_d;
    logic [3:0]      count_q, count_d;
    logic            game_over_q, game_over_d;
    logic            player_q, player_d;
    logic [3:0]      pos_q, pos_d;
    logic [2:0]      idx_q, idx_d;
    logic            win_acc_q, win_acc_d;
    logic            v_q, v_d;
    logic            win_q, win_d;
    logic            tie_q, tie_d;

    logic [11:0]     line;
    logic [1:0]      player_code;
    logic            line_hit;
    logic            reject;

    // Three cell indices of winning line idx, packed {a, b, c}.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    assign line        = line_cells(idx_q);
    assign player_code = player_q ? P1_CODE : P0_CODE;
    assign line_hit    = (board_q[line[11:8]] == player_code) &&
                         (board_q[line[7:4]]  == player_code) &&
                         (board_q[line[3:0]]  == player_code);
    // The cell lookup is only meaningful for legal positions; the range test masks it.
    assign reject      = (pos_q > 4'd8) || game_over_q || (board_q[pos_q] != 2'b00);

    always_comb begin
        // NOTE: every next-state value takes its current value first, so no path infers a latch.
        state_d     = state_q;
        board_d     = board_q;
        count_d     = count_q;
        game_over_d = game_over_q;
        player_d    = player_q;
        pos_d       = pos_q;
        idx_d       = idx_q;
        win_acc_d   = win_acc_q;
        v_d         = v_q;
        win_d       = win_q;
        tie_d       = tie_q;

        case (state_q)
            IDLE: begin
                if (ValidatePlay) begin
                    player_d = Player;
                    pos_d    = position;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    v_d     = 1'b0;
                    win_d   = 1'b0;
                    tie_d   = 1'b0;
                    state_d = REPORT;
                end else begin
                    board_d[pos_q] = player_code;
                    count_d        = (count_q >= 4'd9) ? 4'd9 : count_q + 4'd1;
                    idx_d          = 3'd0;
                    win_acc_d      = 1'b0;
                    state_d        = SCAN;
                end
            end
            SCAN: begin
                win_acc_d = win_acc_q | line_hit;
                idx_d     = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    v_d         = 1'b1;
                    win_d       = win_acc_d;
                    tie_d       = !win_acc_d && (count_q == 4'd9);
                    game_over_d = game_over_q | win_d | tie_d;
                    state_d     = REPORT;
                end
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // New game: aborts any in-flight move but leaves the last verdict visible.
        if (clear) begin
            state_d     = IDLE;
            board_d     = '0;
            count_d     = 4'd0;
            game_over_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            board_q     <= '0;
            count_q     <= 4'd0;
            game_over_q <= 1'b0;
            player_q    <= 1'b0;
            pos_q       <= 4'd0;
            idx_q       <= 3'd0;
            win_acc_q   <= 1'b0;
            v_q         <= 1'b0;
            win_q       <= 1'b0;
            tie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            count_q     <= count_d;
            game_over_q <= game_over_d;
            player_q    <= player_d;
            pos_q       <= pos_d;
            idx_q       <= idx_d;
            win_acc_q   <= win_acc_d;
            v_q         <= v_d;
            win_q       <= win_d;
            tie_q       <= tie_d;
        end
    end

    assign Ready = (state_q == REPORT);
    assign busy  = (state_q != IDLE);
    assign V     = v_q;
    assign Win   = win_q;
    assign Tie   = tie_q;
    assign board = board_q;

endmodule

// File: tb/tb_play_validator.sv
// Self-checking bench for play_validator: directed scenarios plus randomized play,
// all checked against a game-level tic-tac-toe model.
module tb_play_validator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        ValidatePlay;
    logic        Player;
    logic [3:0]  position;
    logic        Ready;
    logic        V;
    logic        Win;
    logic        Tie;
    logic        busy;
    logic [17:0] board;

    int checks   = 0;
    int failures = 0;

    // Game model
    int m_cells [9];
    int m_count;
    bit m_over;
    bit m_v, m_win, m_tie;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    play_validator dut (
        .clk(clk), .rst(rst), .clear(clear), .ValidatePlay(ValidatePlay),
        .Player(Player), .position(position), .Ready(Ready), .V(V), .Win(Win),
        .Tie(Tie), .busy(busy), .board(board)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cells[i][1:0];
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_count = 0;
        m_over  = 1'b0;
    endtask

    task automatic model_move(input bit p, input int pos, output int lat);
        int code;
        bit won;
        code = p ? 2 : 1;
        if (pos > 8 || m_over || m_cells[pos] != 0) begin
            m_v = 0; m_win = 0; m_tie = 0;
            lat = 2;
        end else begin
            m_cells[pos] = code;
            m_count++;
            won = 0;
            for (int l = 0; l < 8; l++)
                if (m_cells[lines[l][0]] == code && m_cells[lines[l][1]] == code &&
                    m_cells[lines[l][2]] == code) won = 1;
            m_v   = 1;
            m_win = won;
            m_tie = !won && (m_count == 9);
            if (m_win || m_tie) m_over = 1;
            lat = 10;
        end
    endtask

    // Issues one request, waits for Ready and compares the verdict with the model.
    task automatic run_move(input bit p, input int pos, input string tag);
        int  lat, n;
        bit  seen;
        model_move(p, pos, lat);
        @(negedge clk);
        Player = p; position = pos[3:0]; ValidatePlay = 1'b1;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            ValidatePlay = 1'b0;
            if (Ready === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s ready_timeout: no Ready within 20 cycles (pos=%0d)", tag, pos);
        end else begin
            checks++;
            if (n !== lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", tag, n, lat);
            end
            checks++;
            if ({V, Win, Tie} !== {m_v, m_win, m_tie}) begin
                failures++;
                $display("FAIL %s verdict: got V/Win/Tie=%b%b%b expected %b%b%b",
                         tag, V, Win, Tie, m_v, m_win, m_tie);
            end
            checks++;
            if (board !== m_board()) begin
                failures++;
                $display("FAIL %s board: got %h expected %h", tag, board, m_board());
            end
        end
        @(posedge clk); #1;
        checks++;
        if (Ready !== 1'b0 || busy !== 1'b0 || {V, Win, Tie} !== {m_v, m_win, m_tie}) begin
            failures++;
            $display("FAIL %s after_report: got Ready=%b busy=%b VWT=%b%b%b expected 0 0 %b%b%b",
                     tag, Ready, busy, V, Win, Tie, m_v, m_win, m_tie);
        end
    endtask

    task automatic clear_game(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        checks++;
        if (board !== 18'h0 || busy !== 1'b0 || Ready !== 1'b0 ||
            {V, Win, Tie} !== {m_v, m_win, m_tie}) begin
            failures++;
            $display("FAIL %s clear: got board=%h busy=%b Ready=%b VWT=%b%b%b expected 0 0 0 %b%b%b",
                     tag, board, busy, Ready, V, Win, Tie, m_v, m_win, m_tie);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; ValidatePlay = 1'b0; Player = 1'b0; position = 4'd0;
        m_v = 0; m_win = 0; m_tie = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (board !== 18'h0 || Ready !== 1'b0 || V !== 1'b0 || Win !== 1'b0 ||
            Tie !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got board=%h Ready=%b V=%b Win=%b Tie=%b busy=%b expected all 0",
                     board, Ready, V, Win, Tie, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || Ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got busy=%b Ready=%b expected 0 0", i, busy, Ready);
            end
        end
    endtask

    task automatic test_accept();
        run_move(1'b0, 4, "accept_center");
    endtask

    task automatic test_reject();
        run_move(1'b1, 4, "reject_occupied");
        run_move(1'b1, 12, "reject_range");
    endtask

    task automatic test_win();
        clear_game("win");
        run_move(1'b0, 0, "win_m1");
        run_move(1'b1, 3, "win_m2");
        run_move(1'b0, 1, "win_m3");
        run_move(1'b1, 5, "win_m4");
        run_move(1'b0, 2, "win_row0");
        run_move(1'b1, 8, "win_game_over");
    endtask

    task automatic test_tie();
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        clear_game("tie");
        for (int i = 0; i < 9; i++) run_move(i[0], seq[i], "tie_seq");
    endtask

    task automatic test_clear_abort();
        int ready_seen;
        clear_game("abort");
        @(negedge clk);
        Player = 1'b0; position = 4'd0; ValidatePlay = 1'b1;
        @(posedge clk); #1;
        ValidatePlay = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (board !== 18'h0 || busy !== 1'b0 || Ready !== 1'b0 ||
            {V, Win, Tie} !== {m_v, m_win, m_tie}) begin
            failures++;
            $display("FAIL abort_clear: got board=%h busy=%b Ready=%b VWT=%b%b%b expected 0 0 0 %b%b%b",
                     board, busy, Ready, V, Win, Tie, m_v, m_win, m_tie);
        end
        ready_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (Ready === 1'b1) ready_seen++;
        end
        checks++;
        if (ready_seen !== 0) begin
            failures++;
            $display("FAIL abort_no_ready: got %0d Ready pulses expected 0", ready_seen);
        end
        // clear and a request in the same IDLE cycle: the request is dropped
        @(negedge clk);
        clear = 1'b1; ValidatePlay = 1'b1; Player = 1'b1; position = 4'd0;
        @(posedge clk); #1;
        clear = 1'b0; ValidatePlay = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1 || Ready === 1'b1) ready_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (ready_seen !== 0 || board !== 18'h0) begin
            failures++;
            $display("FAIL clear_vs_request: got %0d busy/Ready cycles board=%h expected 0 0",
                     ready_seen, board);
        end
        run_move(1'b0, 0, "after_abort");
    endtask

    task automatic test_busy_ignored();
        int lat, pulses;
        model_move(1'b1, 1, lat);
        @(negedge clk);
        Player = 1'b1; position = 4'd1; ValidatePlay = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (Ready === 1'b1) pulses++;
            ValidatePlay = (c == 3 || c == 6);
            Player   = 1'b0;
            position = 4'd2;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL busy_ignored pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (board !== m_board() || {V, Win, Tie} !== {m_v, m_win, m_tie}) begin
            failures++;
            $display("FAIL busy_ignored state: got board=%h VWT=%b%b%b expected %h %b%b%b",
                     board, V, Win, Tie, m_board(), m_v, m_win, m_tie);
        end
    endtask

    task automatic test_random();
        int pos;
        bit p;
        clear_game("random");
        for (int i = 0; i < 70; i++) begin
            if ((m_over && $urandom_range(0, 1) == 0) || $urandom_range(0, 19) == 0)
                clear_game("random");
            p   = 1'($urandom_range(0, 1));
            pos = ($urandom_range(0, 4) == 0) ? int'($urandom_range(9, 15))
                                              : int'($urandom_range(0, 8));
            run_move(p, pos, "random");
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_win();
        test_tie();
        test_clear_abort();
        test_busy_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/play_validator.md
Name: play_validator

Overview:
- Responder side of the game controller's ValidatePlay / Ready / V / Win / Tie interface for the 3x3 tic-tac-toe board.
- Owns the board storage and accepts one play request at a time.
- Checks and commits the move, then scans the 8 winning lines one per cycle.
- Returns a single-cycle Ready pulse carrying the verdict flags V, Win and Tie.

Parameters:
- P0_CODE, 2'b01, cell code written for Player=0.
- P1_CODE, 2'b10, cell code written for Player=1. Must differ from P0_CODE and from 2'b00 (empty).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous new-game request: empties the board.
- ValidatePlay  input  1  request strobe; sampled only in IDLE.
- Player  input  1  player making the move; latched with the request.
- position  input  4  target cell 0..8; values 9..15 are illegal.
- Ready  output  1  one-cycle pulse; verdict valid in this cycle.
- V  output  1  move accepted and committed.
- Win  output  1  accepted move completed a line for Player.
- Tie  output  1  accepted move filled the board without a win.
- busy  output  1  high in every state except IDLE.
- board  output  18  board[2i+1:2i] = cell i (row i/3, col i%3); 00 = empty.

Behaviour:
- Reset (rst=1 at an edge, any state):
  - State -> IDLE.
  - Board all 00, move count 0, game_over 0.
  - Ready, V, Win, Tie, busy all 0.
  - rst has priority over clear.
- clear=1 (rst=0), any state:
  - Same effect as reset, except V/Win/Tie keep their values.
  - An in-flight request is aborted and produces no Ready.
- State IDLE:
  - ValidatePlay=1 latches Player and position -> CHECK.
  - ValidatePlay while busy=1 is ignored (no queueing).
- State CHECK (1 cycle). The move is rejected when any of these holds:
  - position > 8;
  - the target cell is not 00;
  - game_over=1.
  - Rejected: go to REPORT with V=0, Win=0, Tie=0.
  - Otherwise: write the player code into the cell, count++, line index <- 0, go to SCAN.
- State SCAN (exactly 8 cycles, no early exit):
  - Each cycle evaluates line[idx] against the latched player's code.
  - Line order: {0,1,2}, {3,4,5}, {6,7,8}, {0,3,6}, {1,4,7}, {2,5,8}, {0,4,8}, {2,4,6}.
  - The win flag is sticky (OR of all 8 matches).
  - idx 0..7 wraps to REPORT after idx 7.
- State REPORT (1 cycle):
  - Ready=1; V, Win, Tie are registered on entry.
  - V=1, Win=winflag, Tie=~winflag & (count==9).
  - Win or Tie sets game_over.
  - Next state IDLE.
- Flag persistence: V, Win and Tie hold until the next REPORT (or reset); Ready is a single-cycle pulse.
- Latency, with the request sampled at edge k:
  - Rejected move: Ready in the cycle after edge k+1 (2 cycles).
  - Accepted move: Ready in the cycle after edge k+9 (10 cycles).
- Board visibility: the board output reflects the committed cell from the cycle after CHECK.
- Width: count is 4 bits, saturates at 9, never wraps.
- Simultaneous events: ValidatePlay together with clear in IDLE -> clear wins and the request is dropped.

Test Plan:
- Reset, then board, Ready, V, Win, Tie, busy are all checked.
  - Expect 0 throughout.
  - busy stays 0 for 5 idle cycles.
- Player=0, position=4 -> Ready 10 cycles later with V=1, Win=0, Tie=0.
  - board[9:8]=01, count=1.
- Repeat position=4 with Player=1, then position=12 -> both rejected.
  - Ready at 2 cycles with V=0.
  - board unchanged.
- Player 0 plays cells 0 and 1, player 1 plays cells 3 and 5, then player 0 plays cell 2.
  - Final Ready gives V=1, Win=1 (row 0).
  - A further request at cell 8 gives V=0 (game_over).
- Sequence 0(P0), 1(P1), 2(P0), 4(P1), 3(P0), 5(P1), 7(P0), 6(P1), 8(P0) with no line formed.
  - Last Ready gives V=1, Win=0, Tie=1.
- Assert clear 4 cycles into a SCAN.
  - No Ready is issued; board=0 and busy=0 next cycle.
  - Request at position 0 then succeeds with V=1.
  - Also: ValidatePlay during busy is ignored and produces exactly one Ready.
